// File: rtl/fft_result_reader.sv
// fft_result_reader: drains banks m0/m1 in natural or bit-reversed order through a 3-entry output FIFO
module fft_result_reader #(
    parameter int R = 5,
    parameter int N = 32,
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic         i_bitrev,
    output logic         o_re0,
    output logic         o_re1,
    output logic [R-2:0] o_a0,
    output logic [R-2:0] o_a1,
    input  logic [W-1:0] i_d0,
    input  logic [W-1:0] i_d1,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_last,
    output logic         o_busy,
    output logic         o_done
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    state_t state, state_n;
    logic [R-1:0] k, k_rev, n;
    logic bitrev_q, armed, issue, bank, inflight, infl_bank, infl_last, push, pop;
    logic [1:0] count, wr_ptr, rd_ptr;
    logic [W-1:0] fifo_data [3];
    logic [2:0] fifo_last;
    always_comb begin
        k_rev = '0;
        for (int i = 0; i < R; i++) k_rev[i] = k[R-1-i];
    end
    assign n = bitrev_q ? k_rev : k;
    assign bank = ^n;
    assign issue = state == READ && armed && (3'(count) + 3'(inflight)) < 3'd3;
    assign o_re0 = issue && !bank;
    assign o_re1 = issue && bank;
    assign o_a0 = o_re0 ? n[R-1:1] : '0;
    assign o_a1 = o_re1 ? n[R-1:1] : '0;
    assign push = inflight;
    assign o_valid = count != 2'd0;
    assign pop = o_valid && i_ready;
    assign o_data = fifo_data[rd_ptr];
    assign o_last = o_valid && fifo_last[rd_ptr];
    assign o_busy = state != IDLE;
    always_comb begin
        state_n = (state == IDLE && i_start) ? READ :
                  (state == READ && issue && k == R'(N-1)) ? DRAIN :
                  (state == DRAIN && pop && o_last) ? IDLE : state;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            k <= '0;
            bitrev_q <= 1'b0;
            armed <= 1'b0;
            inflight <= 1'b0;
            infl_bank <= 1'b0;
            infl_last <= 1'b0;
            count <= 2'd0;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            o_done <= 1'b0;
        end else begin
            state <= state_n;
            armed <= state == READ;
            if (state == IDLE && i_start) begin
                bitrev_q <= i_bitrev;
                k <= '0;
            end else if (issue) begin
                k <= k + 1'b1;
            end
            inflight <= issue;
            infl_bank <= bank;
            infl_last <= k == R'(N-1);
            if (push) wr_ptr <= wr_ptr == 2'd2 ? 2'd0 : wr_ptr + 2'd1;
            if (pop) rd_ptr <= rd_ptr == 2'd2 ? 2'd0 : rd_ptr + 2'd1;
            count <= count + 2'(push) - 2'(pop);
            o_done <= pop && o_last;
        end
    end
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= infl_bank ? i_d1 : i_d0;
            fifo_last[wr_ptr] <= infl_last;
        end
    end
endmodule

// File: tb/tb_fft_result_reader.sv
// tb_fft_result_reader: directed checks of order, timing, backpressure, restart and reset abort
module tb_fft_result_reader;
    localparam int R = 5;
    localparam int N = 32;
    localparam int W = 32;
    logic i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_bitrev = 1'b0, i_ready = 1'b1;
    logic o_re0, o_re1, o_valid, o_last, o_busy, o_done;
    logic [R-2:0] o_a0, o_a1;
    logic [W-1:0] i_d0, i_d1, o_data;
    logic [W-1:0] m0 [16];
    logic [W-1:0] m1 [16];
    logic [W-1:0] got_d [$];
    logic got_l [$];
    int got_e [$];
    logic rd_b [$];
    logic [R-2:0] rd_a [$];
    int rd_cyc [$];
    int cyc = 0, s_cyc = 0, done_cnt = 0, done_cyc = 0, viol = 0, ovf = 0;
    int total = 0, bad = 0;

    fft_result_reader #(.R(R), .N(N), .W(W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_bitrev(i_bitrev),
        .o_re0(o_re0), .o_re1(o_re1), .o_a0(o_a0), .o_a1(o_a1),
        .i_d0(i_d0), .i_d1(i_d1), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        for (int i = 0; i < N; i++) begin
            logic [4:0] v;
            v = 5'(i);
            if (^v) m1[v[4:1]] = 32'(i);
            else m0[v[4:1]] = 32'(i);
        end
    end

    always @(posedge i_clk) begin
        i_d0 <= o_re0 ? m0[o_a0] : 32'hDEAD_0000;
        i_d1 <= o_re1 ? m1[o_a1] : 32'hDEAD_0001;
        cyc <= cyc + 1;
    end

    always @(negedge i_clk) begin
        if (o_re0 && o_re1) viol++;
        if (!o_re0 && o_a0 != 0) viol++;
        if (!o_re1 && o_a1 != 0) viol++;
        if (o_re0 || o_re1) begin
            rd_b.push_back(o_re1);
            rd_a.push_back(o_re1 ? o_a1 : o_a0);
            rd_cyc.push_back(cyc - s_cyc);
        end
        if (o_valid && i_ready) begin
            got_d.push_back(o_data);
            got_l.push_back(o_last);
            got_e.push_back(cyc - s_cyc + 1);
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc - s_cyc;
        end
        if (rd_b.size() - got_d.size() > 3) ovf++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] rev5(input logic [4:0] x);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = x[4-i];
        return r;
    endfunction

    task automatic do_start(input logic b);
        got_d.delete(); got_l.delete(); got_e.delete();
        rd_b.delete(); rd_a.delete(); rd_cyc.delete();
        done_cnt = 0; done_cyc = 0; viol = 0; ovf = 0;
        i_start = 1'b1;
        i_bitrev = b;
        @(posedge i_clk); #1;
        s_cyc = cyc;
        i_start = 1'b0;
        i_bitrev = 1'b0;
    endtask

    task automatic run_until_idle(input int limit, output bit to);
        to = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(posedge i_clk); #1;
            if (done_cnt != 0 && !o_done) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge i_clk);
        #1;
        total++;
        if ({o_re0, o_re1, o_a0, o_a1, o_valid, o_last, o_busy, o_done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0", {o_re0, o_re1, o_a0, o_a1, o_valid, o_last, o_busy, o_done});
        end
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        total++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_idle: busy=%b valid=%b want 0 0", o_busy, o_valid);
        end
    endtask

    task automatic test_natural;
        bit to;
        int nl;
        do_start(1'b0);
        total++;
        if (o_busy !== 1'b1) begin bad++; $display("FAIL nat_busy: got %b want 1", o_busy); end
        run_until_idle(100, to);
        total++;
        if (to) begin bad++; $display("FAIL nat_timeout: got no done want done"); end
        total++;
        if (got_d.size() != N) begin bad++; $display("FAIL nat_count: got %0d want %0d", got_d.size(), N); end
        for (int i = 0; i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== 32'(i)) begin bad++; $display("FAIL nat_data[%0d]: got %0d want %0d", i, got_d[i], i); end
        end
        nl = 0;
        foreach (got_l[i]) if (got_l[i]) nl++;
        total++;
        if (nl != 1 || got_l[N-1] !== 1'b1) begin bad++; $display("FAIL nat_last: got count=%0d last31=%b want 1 1", nl, got_l[N-1]); end
        total++;
        if (rd_cyc[0] != 1) begin bad++; $display("FAIL nat_first_read_cycle: got %0d want 1", rd_cyc[0]); end
        total++;
        if (rd_b[1] !== 1'b1 || rd_a[1] !== 4'd0) begin bad++; $display("FAIL nat_k1_read: got bank=%b a=%0d want 1 0", rd_b[1], rd_a[1]); end
        total++;
        if (rd_b[3] !== 1'b0 || rd_a[3] !== 4'd1) begin bad++; $display("FAIL nat_k3_read: got bank=%b a=%0d want 0 1", rd_b[3], rd_a[3]); end
        total++;
        if (got_e[0] != 4 || got_e[N-1] != N + 3) begin bad++; $display("FAIL nat_handshake_edges: got %0d %0d want 4 %0d", got_e[0], got_e[N-1], N + 3); end
        total++;
        if (done_cnt != 1 || done_cyc != 35) begin bad++; $display("FAIL nat_done: got cnt=%0d cyc=%0d want 1 35", done_cnt, done_cyc); end
        total++;
        if (viol != 0 || ovf != 0) begin bad++; $display("FAIL nat_bus_rules: got viol=%0d ovf=%0d want 0 0", viol, ovf); end
        total++;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL nat_idle_after: got busy=%b want 0", o_busy); end
    endtask

    task automatic test_bitrev;
        bit to;
        do_start(1'b1);
        run_until_idle(100, to);
        total++;
        if (to || got_d.size() != N) begin bad++; $display("FAIL br_count: got %0d timeout=%b want %0d 0", got_d.size(), to, N); end
        total++;
        if (rd_b[1] !== 1'b1 || rd_a[1] !== 4'd8) begin bad++; $display("FAIL br_k1_read: got bank=%b a=%0d want 1 8", rd_b[1], rd_a[1]); end
        total++;
        if (rd_b[2] !== 1'b1 || rd_a[2] !== 4'd4) begin bad++; $display("FAIL br_k2_read: got bank=%b a=%0d want 1 4", rd_b[2], rd_a[2]); end
        total++;
        if (rd_b[3] !== 1'b0 || rd_a[3] !== 4'd12) begin bad++; $display("FAIL br_k3_read: got bank=%b a=%0d want 0 12", rd_b[3], rd_a[3]); end
        for (int i = 0; i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== 32'(rev5(5'(i)))) begin bad++; $display("FAIL br_data[%0d]: got %0d want %0d", i, got_d[i], rev5(5'(i))); end
        end
        total++;
        if (got_l[N-1] !== 1'b1 || done_cnt != 1) begin bad++; $display("FAIL br_last_done: got last=%b done=%0d want 1 1", got_l[N-1], done_cnt); end
    endtask

    task automatic test_backpressure;
        bit to;
        int n_rd;
        logic [W-1:0] held;
        do_start(1'b0);
        for (int i = 0; i < 100; i++) begin
            @(posedge i_clk); #1;
            if (got_d.size() >= 8) break;
        end
        i_ready = 1'b0;
        held = 32'(got_d.size());
        n_rd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            total++;
            if (o_valid !== 1'b1 || o_data !== held) begin bad++; $display("FAIL bp_stable[%0d]: got valid=%b data=%0d want 1 %0d", i, o_valid, o_data, held); end
            if (i == 5) n_rd = rd_b.size();
            @(posedge i_clk); #1;
        end
        total++;
        if (rd_b.size() != n_rd) begin bad++; $display("FAIL bp_reads_stopped: got %0d reads want %0d", rd_b.size(), n_rd); end
        total++;
        if (rd_b.size() - got_d.size() != 3) begin bad++; $display("FAIL bp_fill: got outstanding=%0d want 3", rd_b.size() - got_d.size()); end
        i_ready = 1'b1;
        run_until_idle(100, to);
        total++;
        if (to || got_d.size() != N) begin bad++; $display("FAIL bp_count: got %0d timeout=%b want %0d 0", got_d.size(), to, N); end
        for (int i = 0; i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== 32'(i)) begin bad++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, got_d[i], i); end
        end
        total++;
        if (ovf != 0 || viol != 0 || done_cnt != 1) begin bad++; $display("FAIL bp_rules: got ovf=%0d viol=%0d done=%0d want 0 0 1", ovf, viol, done_cnt); end
    endtask

    task automatic test_random_ready;
        bit to;
        to = 1'b1;
        do_start(1'b0);
        for (int i = 0; i < 400; i++) begin
            @(posedge i_clk); #1;
            i_ready = 1'($urandom_range(0, 1));
            if (done_cnt != 0 && !o_done) begin
                to = 1'b0;
                break;
            end
        end
        i_ready = 1'b1;
        repeat (5) @(posedge i_clk);
        #1;
        total++;
        if (to || got_d.size() != N) begin bad++; $display("FAIL rnd_count: got %0d timeout=%b want %0d 0", got_d.size(), to, N); end
        for (int i = 0; i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== 32'(i) || got_l[i] !== (i == N - 1)) begin bad++; $display("FAIL rnd_word[%0d]: got %0d last=%b want %0d last=%b", i, got_d[i], got_l[i], i, i == N - 1); end
        end
        total++;
        if (done_cnt != 1 || ovf != 0) begin bad++; $display("FAIL rnd_done: got done=%0d ovf=%0d want 1 0", done_cnt, ovf); end
    endtask

    task automatic test_start_ignored;
        bit to;
        do_start(1'b0);
        repeat (5) @(posedge i_clk);
        #1;
        i_start = 1'b1;
        i_bitrev = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_bitrev = 1'b0;
        run_until_idle(100, to);
        repeat (5) @(posedge i_clk);
        #1;
        total++;
        if (to || got_d.size() != N || done_cnt != 1) begin bad++; $display("FAIL ign_count: got %0d done=%0d want %0d 1", got_d.size(), done_cnt, N); end
        for (int i = 0; i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== 32'(i)) begin bad++; $display("FAIL ign_data[%0d]: got %0d want %0d", i, got_d[i], i); end
        end
        total++;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL ign_no_restart: got busy=%b want 0", o_busy); end
    endtask

    task automatic test_reset_mid;
        bit to;
        int n_rd, n_got;
        do_start(1'b0);
        for (int i = 0; i < 100; i++) begin
            @(posedge i_clk); #1;
            if (rd_b.size() >= 12) break;
        end
        i_rst_n = 1'b0;
        #1;
        total++;
        if ({o_re0, o_re1, o_a0, o_a1, o_valid, o_last, o_busy, o_done} !== '0) begin
            bad++;
            $display("FAIL rstmid_outputs: got %b want 0", {o_re0, o_re1, o_a0, o_a1, o_valid, o_last, o_busy, o_done});
        end
        n_rd = rd_b.size();
        n_got = got_d.size();
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        total++;
        if (rd_b.size() != n_rd || got_d.size() != n_got || o_valid !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_quiet: got reads=%0d words=%0d valid=%b busy=%b want %0d %0d 0 0", rd_b.size(), got_d.size(), o_valid, o_busy, n_rd, n_got);
        end
        do_start(1'b0);
        run_until_idle(100, to);
        total++;
        if (to || got_d.size() != N || done_cnt != 1) begin bad++; $display("FAIL rstmid_restart: got %0d done=%0d want %0d 1", got_d.size(), done_cnt, N); end
        total++;
        if (rd_b[0] !== 1'b0 || rd_a[0] !== 4'd0 || rd_cyc[0] != 1) begin bad++; $display("FAIL rstmid_k0: got bank=%b a=%0d cyc=%0d want 0 0 1", rd_b[0], rd_a[0], rd_cyc[0]); end
        for (int i = 0; i < got_d.size(); i++) begin
            total++;
            if (got_d[i] !== 32'(i)) begin bad++; $display("FAIL rstmid_data[%0d]: got %0d want %0d", i, got_d[i], i); end
        end
    endtask

    initial begin
        test_reset;
        test_natural;
        test_bitrev;
        test_backpressure;
        test_random_ready;
        test_start_ignored;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_result_reader.md
FFT_RESULT_READER -- requirements
Module: fft_result_reader

Interface
REQ-001 Parameter R, default 5, meaning log2 of FFT length.
REQ-002 Parameter N, default 32, meaning FFT length (2^R).
REQ-003 Parameter W, default 32, meaning sample width (packed complex word).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low, with ports named as below.
REQ-005 i_clk  input  1  clock, all state on rising edge.
REQ-006 i_rst_n  input  1  asynchronous active-low reset.
REQ-007 i_start  input  1  one-cycle pulse; begins draining the FFT result.
REQ-008 i_bitrev  input  1  order select, sampled with i_start; 1 = read bit-reversed index, 0 = natural.
REQ-009 o_re0 / o_re1  output  1 each  read enable, bank m0 / m1.
REQ-010 o_a0 / o_a1  output  R-1 each  read address, bank m0 / m1.
REQ-011 i_d0 / i_d1  input  W each  read data, bank m0 / m1, valid the cycle after the enable.
REQ-012 o_valid  output  1  output word valid.
REQ-013 i_ready  input  1  downstream accepts the word.
REQ-014 o_data  output  W  output word.
REQ-015 o_last  output  1  marks element k = N-1.
REQ-016 o_busy  output  1  high whenever state is not IDLE.
REQ-017 o_done  output  1  one-cycle pulse after the last handshake.

Function
REQ-018 The FSM SHALL have states IDLE, READ and DRAIN.
- IDLE->READ on i_start.
- READ->DRAIN after the read for k = N-1 issues.
- DRAIN->IDLE on the handshake of the o_last word.
REQ-019 The element counter k SHALL run 0..N-1 and increment only on an issued read; n = i_bitrev_latched ? bitrev_R(k) : k.
REQ-020 Bank mapping SHALL be bank = XOR of all R bits of n and address = n[R-1:1].
- Bank 0 drives o_re0/o_a0; bank 1 drives o_re1/o_a1.
- At most one enable is high per cycle.
- The unused address holds 0.
REQ-021 A read SHALL issue in READ only when fifo_count + inflight < 3, where inflight = a read issued the previous cycle; the issue decision SHALL NOT depend combinationally on i_ready.
REQ-022 The bank of each issued read SHALL be registered with it, so the data returning one cycle later is captured from the matching i_d0/i_d1 into a 3-entry output FIFO.
REQ-023 The FIFO SHALL carry a last flag alongside each word; o_valid = FIFO non-empty; o_data and o_last come from the FIFO head.
REQ-024 A handshake SHALL be o_valid && i_ready; a push and a pop in the same cycle SHALL keep the count unchanged; the FIFO SHALL never overflow.
REQ-025 o_data SHALL hold stable while o_valid && !i_ready.
REQ-026 With i_ready held 1, a read issued in cycle c SHALL handshake at edge c+3 (start sampled at edge 0).
- First read in cycle 1; one word per cycle.
- Last handshake at edge N+3.
REQ-027 o_done SHALL be high exactly one cycle following the o_last handshake.
REQ-028 i_start while o_busy SHALL be ignored; i_bitrev is latched only at an accepted i_start.

Reset
REQ-029 While i_rst_n = 0, the following SHALL be 0: state = IDLE, k, inflight, FIFO count and pointers, latched order, o_re0, o_re1, o_a0, o_a1, o_valid, o_last, o_busy, o_done.
REQ-030 Reset asserted mid-operation SHALL abort the drain with no further reads or outputs; read data returning after reset release SHALL be discarded.

Verification
REQ-031 Natural order, i_ready = 1, bank m_b[a] preloaded with index n:
- k=1 -> o_re1, a1 = 0; k=3 -> o_re0, a0 = 1.
- Outputs 0..31 in order; o_last on 31; o_done at cycle 35.
REQ-032 Bit-reversed, i_ready = 1:
- k=1 -> n=16 (bank 1, a1 = 8); k=2 -> n=8 (bank 1, a1 = 4); k=3 -> n=24 (bank 0, a0 = 12).
- Output sequence is bitrev order.
REQ-033 Backpressure: i_ready low for 10 cycles mid-drain:
- Reads stop with the FIFO count at 3 and no overflow.
- o_data stable while stalled.
- Sequence complete and unduplicated after release.
REQ-034 Random i_ready (50%): all 32 words delivered exactly once, in order; the o_last word is 31; exactly one o_done pulse.
REQ-035 i_start reasserted during READ with i_bitrev flipped: ignored; order unchanged; single o_done.
REQ-036 i_rst_n pulsed low at k = 12:
- All outputs go to 0 immediately.
- Then a fresh i_start yields a full 32-word drain from k = 0.
